riscv_fetch_stage: RTL and testbench

//  IF stage of the pipelined RV32I core; sits directly upstream of decode/hazard logic.

---
 rtl/riscv_fetch_stage.sv | 141 ++++++++++++++
 tb/tb_riscv_fetch_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage
//   Instruction-fetch stage of the pipelined RV32I core. Owns the fetch PC,
//   issues instruction-memory requests and loads the IF/ID pipeline register.
//   An instruction that arrives while decode is stalled is parked in a
//   one-entry hold buffer, so it is never fetched a second time.
//
//   Ports
//     clk         in   1   rising-edge clock
//     reset       in   1   synchronous reset, active low (0 = reset)
//     en_fetch    in   1   1 = IF/ID may advance, 0 = stall from hazard unit
//     flush_d     in   1   1 = load a bubble into IF/ID on this edge
//     PCSrc       in   1   E-stage redirect taken
//     PCTargetE   in   32  redirect target, bits [1:0] ignored
//     imem_req    out  1   fetch request valid
//     imem_addr   out  32  fetch address (always PCF)
//     imem_ready  in   1   imem_rdata valid this cycle
//     imem_rdata  in   32  fetched instruction
//     PCF         out  32  current fetch PC
//     InstrD      out  32  IF/ID instruction
//     PCD         out  32  IF/ID PC
//     PCPlus4D    out  32  IF/ID PC + 4
//     ValidD      out  1   IF/ID holds a real instruction
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_FETCH | request outstanding at PCF, hold buffer empty
//   S_HOLD  | buffer holds the instruction at PCF-4, no request issued

module riscv_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_fetch,
  input  logic        flush_d,
  input  logic        PCSrc,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pcf;
  logic [31:0] r_buf;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc4_d;
  logic        r_valid_d;

  logic        w_req;
  logic        w_accept;
  logic [31:0] w_pcf_plus4;
  logic [31:0] w_pcf_minus4;
  logic [31:0] w_target;

  // Request depends only on reset and state, never on the hazard inputs,
  // which keeps the hazard unit out of the memory request timing path.
  assign w_req        = reset & (r_state == S_FETCH);
  assign w_accept     = w_req & imem_ready;
  assign w_pcf_plus4  = r_pcf + 32'd4;
  assign w_pcf_minus4 = r_pcf - 32'd4;
  // Redirect targets are word aligned; masking keeps every input bit in use.
  assign w_target     = PCTargetE & ~32'h0000_0003;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_pcf     <= RESET_PC;
      r_buf     <= NOP_INSTR;
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= 32'd0;
      r_pc4_d   <= 32'd0;
      r_valid_d <= 1'b0;
    end else if (PCSrc) begin
      // Redirect wins over everything: drop the buffer and any response
      // arriving this cycle, restart fetching at the target.
      r_state <= S_FETCH;
      r_pcf   <= w_target;
      r_buf   <= NOP_INSTR;
      if (flush_d || en_fetch) begin
        r_instr_d <= NOP_INSTR;
        r_valid_d <= 1'b0;
      end
    end else if (flush_d) begin
      // Bubble into ID; PCD/PCPlus4D deliberately left as they were.
      r_state   <= S_FETCH;
      r_buf     <= NOP_INSTR;
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
      if (w_accept) begin
        r_pcf <= w_pcf_plus4;
      end
    end else if (!en_fetch) begin
      // Stall: capture a response rather than re-fetching it later.
      if (w_accept) begin
        r_buf   <= imem_rdata;
        r_pcf   <= w_pcf_plus4;
        r_state <= S_HOLD;
      end
    end else if (r_state == S_HOLD) begin
      // PCF already points past the held instruction.
      r_instr_d <= r_buf;
      r_pc_d    <= w_pcf_minus4;
      r_pc4_d   <= r_pcf;
      r_valid_d <= 1'b1;
      r_state   <= S_FETCH;
    end else if (w_accept) begin
      r_instr_d <= imem_rdata;
      r_pc_d    <= r_pcf;
      r_pc4_d   <= w_pcf_plus4;
      r_valid_d <= 1'b1;
      r_pcf     <= w_pcf_plus4;
    end else begin
      // Memory wait state: send a bubble down, keep PCD/PCPlus4D.
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pcf;
  assign PCF       = r_pcf;
  assign InstrD    = r_instr_d;
  assign PCD       = r_pc_d;
  assign PCPlus4D  = r_pc4_d;
  assign ValidD    = r_valid_d;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
module tb_riscv_fetch_stage;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (RESET_PC = 0)
  logic        reset, en_fetch, flush_d, PCSrc, imem_ready;
  logic [31:0] PCTargetE, imem_rdata, junk;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, PCF, InstrD, PCD, PCPlus4D;

  // wrap instance (RESET_PC = FFFF_FFFC)
  logic        w_reset, w_en, w_flush, w_ps, w_ready;
  logic [31:0] w_tgt, w_rdata;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pcf, w_instr, w_pcd, w_pc4;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0F33;
  endfunction

  assign imem_rdata = imem_ready ? mem(imem_addr) : junk;
  assign w_rdata    = w_ready ? mem(w_addr) : 32'hDEAD_BEEF;

  riscv_fetch_stage dut (
    .clk(clk), .reset(reset), .en_fetch(en_fetch), .flush_d(flush_d),
    .PCSrc(PCSrc), .PCTargetE(PCTargetE), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  riscv_fetch_stage #(.RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .reset(w_reset), .en_fetch(w_en), .flush_d(w_flush),
    .PCSrc(w_ps), .PCTargetE(w_tgt), .imem_req(w_req),
    .imem_addr(w_addr), .imem_ready(w_ready), .imem_rdata(w_rdata),
    .PCF(w_pcf), .InstrD(w_instr), .PCD(w_pcd), .PCPlus4D(w_pc4), .ValidD(w_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst, en, fl, ps;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] pcf, instr, pcd, pc4;
    logic        valid;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic en, input logic fl,
                              input logic ps, input logic [31:0] tgt, input logic rdy,
                              input logic req, input logic [31:0] pcf,
                              input logic valid, input logic [31:0] instr,
                              input logic [31:0] pcd, input logic [31:0] pc4);
    vec_t v;
    v.rst = rst; v.en = en; v.fl = fl; v.ps = ps; v.tgt = tgt; v.rdy = rdy;
    v.req = req; v.pcf = pcf; v.valid = valid; v.instr = instr; v.pcd = pcd; v.pc4 = pc4;
    return v;
  endfunction

  // reference model state: fetch PC, parked instructions, ID contents
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic [31:0] m_instr, m_pcd, m_pc4;
  logic        m_valid;

  task automatic model_bubble();
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic rst, input logic en, input logic fl,
                            input logic ps, input logic [31:0] tgt, input logic rdy);
    logic got;
    got = rst && (m_q.size() == 0) && rdy;
    if (!rst) begin
      m_pc = 32'd0; m_q.delete();
      m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
    end else if (ps) begin
      m_pc = {tgt[31:2], 2'b00};
      m_q.delete();
      if (fl || en) model_bubble();
    end else if (fl) begin
      model_bubble();
      m_q.delete();
      if (got) m_pc = m_pc + 4;
    end else if (!en) begin
      if (got) begin m_q.push_back(mem(m_pc)); m_pc = m_pc + 4; end
    end else if (m_q.size() != 0) begin
      m_instr = m_q.pop_front(); m_pcd = m_pc - 4; m_pc4 = m_pc; m_valid = 1;
    end else if (got) begin
      m_instr = mem(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 4; m_valid = 1;
      m_pc = m_pc + 4;
    end else begin
      model_bubble();
    end
  endtask

  task automatic wstep(input logic rst, input logic en, input logic exp_req);
    @(negedge clk);
    w_reset = rst; w_en = en; w_ready = 1'b1;
    #1 chk("wrap_req", {31'd0, w_req}, {31'd0, exp_req});
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[19];

  initial begin
    reset = 0; en_fetch = 1; flush_d = 0; PCSrc = 0; PCTargetE = 0; imem_ready = 1; junk = 0;
    w_reset = 0; w_en = 1; w_flush = 0; w_ps = 0; w_tgt = 0; w_ready = 1;

    //           rst en fl ps tgt        rdy req pcf          vld instr          pcd          pc4
    tbl[0]  = mk(0, 1, 0, 0, 32'h0,    1,  0, 32'h0,     0, NOP,           32'h0,     32'h0);
    tbl[1]  = mk(0, 1, 0, 0, 32'h0,    1,  0, 32'h0,     0, NOP,           32'h0,     32'h0);
    tbl[2]  = mk(1, 1, 0, 0, 32'h0,    1,  1, 32'h4,     1, mem(32'h0),    32'h0,     32'h4);
    tbl[3]  = mk(1, 1, 0, 0, 32'h0,    1,  1, 32'h8,     1, mem(32'h4),    32'h4,     32'h8);
    tbl[4]  = mk(1, 0, 0, 0, 32'h0,    1,  1, 32'hC,     1, mem(32'h4),    32'h4,     32'h8);
    tbl[5]  = mk(1, 0, 0, 0, 32'h0,    1,  0, 32'hC,     1, mem(32'h4),    32'h4,     32'h8);
    tbl[6]  = mk(1, 0, 0, 0, 32'h0,    1,  0, 32'hC,     1, mem(32'h4),    32'h4,     32'h8);
    tbl[7]  = mk(1, 1, 0, 0, 32'h0,    1,  0, 32'hC,     1, mem(32'h8),    32'h8,     32'hC);
    tbl[8]  = mk(1, 1, 0, 0, 32'h0,    1,  1, 32'h10,    1, mem(32'hC),    32'hC,     32'h10);
    tbl[9]  = mk(1, 1, 0, 0, 32'h0,    0,  1, 32'h10,    0, NOP,           32'hC,     32'h10);
    tbl[10] = mk(1, 1, 0, 0, 32'h0,    0,  1, 32'h10,    0, NOP,           32'hC,     32'h10);
    tbl[11] = mk(1, 1, 0, 0, 32'h0,    1,  1, 32'h14,    1, mem(32'h10),   32'h10,    32'h14);
    tbl[12] = mk(1, 0, 0, 0, 32'h0,    1,  1, 32'h18,    1, mem(32'h10),   32'h10,    32'h14);
    tbl[13] = mk(1, 0, 0, 1, 32'h103,  1,  0, 32'h100,   1, mem(32'h10),   32'h10,    32'h14);
    tbl[14] = mk(1, 1, 0, 0, 32'h0,    1,  1, 32'h104,   1, mem(32'h100),  32'h100,   32'h104);
    tbl[15] = mk(1, 0, 1, 0, 32'h0,    1,  1, 32'h108,   0, NOP,           32'h100,   32'h104);
    tbl[16] = mk(1, 1, 0, 0, 32'h0,    1,  1, 32'h10C,   1, mem(32'h108),  32'h108,   32'h10C);
    tbl[17] = mk(1, 1, 0, 1, 32'h200,  0,  1, 32'h200,   0, NOP,           32'h108,   32'h10C);
    tbl[18] = mk(1, 1, 0, 0, 32'h0,    1,  1, 32'h204,   1, mem(32'h200),  32'h200,   32'h204);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; en_fetch = tbl[i].en; flush_d = tbl[i].fl;
      PCSrc = tbl[i].ps; PCTargetE = tbl[i].tgt; imem_ready = tbl[i].rdy;
      junk = $urandom;
      #1 chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
      if (i > 0) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i-1].pcf);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pcf", i), PCF, tbl[i].pcf);
      chk($sformatf("vec%0d_valid", i), {31'd0, ValidD}, {31'd0, tbl[i].valid});
      chk($sformatf("vec%0d_instr", i), InstrD, tbl[i].instr);
      chk($sformatf("vec%0d_pcd", i), PCD, tbl[i].pcd);
      chk($sformatf("vec%0d_pc4", i), PCPlus4D, tbl[i].pc4);
    end

    // randomized run against the reference model, starting from reset
    m_pc = 0; m_q.delete(); m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
    for (int c = 0; c < 3000; c++) begin
      logic exp_req;
      @(negedge clk);
      reset      = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      en_fetch   = ($urandom_range(0, 3) != 0);
      flush_d    = ($urandom_range(0, 9) == 0);
      PCSrc      = ($urandom_range(0, 11) == 0);
      PCTargetE  = $urandom;
      imem_ready = ($urandom_range(0, 3) != 0);
      junk       = $urandom;
      exp_req    = reset && (m_q.size() == 0);
      #1 chk("rnd_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) chk("rnd_addr", imem_addr, m_pc);
      @(posedge clk);
      model_step(reset, en_fetch, flush_d, PCSrc, PCTargetE, imem_ready);
      #1;
      chk("rnd_pcf", PCF, m_pc);
      chk("rnd_valid", {31'd0, ValidD}, {31'd0, m_valid});
      chk("rnd_instr", InstrD, m_instr);
      chk("rnd_pcd", PCD, m_pcd);
      chk("rnd_pc4", PCPlus4D, m_pc4);
      if (ValidD) chk("rnd_instr_matches_pcd", InstrD, mem(PCD));
    end

    // wrap-around PC and reset while holding
    wstep(0, 1, 0);
    chk("wrap_reset_pcf", w_pcf, WRAP_PC);
    wstep(1, 1, 1);
    chk("wrap_pcf", w_pcf, 32'h0);
    chk("wrap_pcd", w_pcd, WRAP_PC);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_instr", w_instr, mem(WRAP_PC));
    chk("wrap_valid", {31'd0, w_valid}, 32'd1);
    wstep(1, 1, 1);
    chk("wrap_pcf2", w_pcf, 32'h4);
    chk("wrap_pcd2", w_pcd, 32'h0);
    wstep(1, 0, 1);
    chk("wrap_hold_pcf", w_pcf, 32'h8);
    chk("wrap_hold_pcd", w_pcd, 32'h0);
    wstep(1, 0, 0);
    wstep(0, 0, 0);
    chk("wrap_midhold_reset_pcf", w_pcf, WRAP_PC);
    chk("wrap_midhold_reset_valid", {31'd0, w_valid}, 32'd0);
    chk("wrap_midhold_reset_instr", w_instr, NOP);
    wstep(1, 1, 1);
    chk("wrap_after_reset_pcd", w_pcd, WRAP_PC);
    chk("wrap_after_reset_instr", w_instr, mem(WRAP_PC));
    chk("wrap_after_reset_pcf", w_pcf, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
